// File: rtl/dtc_pkg.sv
// Shared defaults, FSM state type and the saturating counter helper for the DTC receive path.
package dtc_pkg;
    localparam int WORD_W = 256;
    localparam int DEPTH  = 24;
    localparam int ADDR_W = 5;
    localparam int CNT_W  = 16;

    typedef enum logic {HUNT, LOCKED} dtc_state_e;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction
endpackage

// File: rtl/dtc_deser_shift.sv
// Serial-to-parallel capture: stores one bit per strobe at bit_idx, emits the word and a done pulse on the last bit.
module dtc_deser_shift #(
    parameter int WIDTH = 256,
    parameter int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             din,
    input  logic             store,
    input  logic             restart,
    output logic [IDX_W-1:0] bit_idx,
    output logic [WIDTH-1:0] word,
    output logic             done
);
    // Top bit never needs storage: it goes straight into the word on transfer.
    logic [WIDTH-2:0] shreg;
    logic [IDX_W-1:0] idx;

    assign idx = restart ? '0 : bit_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg   <= '0;
            bit_idx <= '0;
            word    <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (store) begin
                if (idx == IDX_W'(WIDTH-1)) begin
                    word    <= {din, shreg};
                    done    <= 1'b1;
                    bit_idx <= '0;
                end else begin
                    shreg[idx] <= din;
                    bit_idx    <= idx + IDX_W'(1);
                end
            end
        end
    end
endmodule

// File: rtl/dtc_deser.sv
// DTC receive deserializer: frame alignment, capture BRAM write port, status counters.
// Optional expected-data checker enabled by defining DTC_DESER_CHECK_EN.
module dtc_deser
    import dtc_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              sr_in,
    input  logic              sr_valid,
    input  logic              frame_sync,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [WORD_W-1:0] wr_data,
    output logic              locked,
    output logic              frame_err,
    output logic [CNT_W-1:0]  word_count
`ifdef DTC_DESER_CHECK_EN
    ,
    input  logic [WORD_W-1:0] exp_data,
    output logic              mismatch,
    output logic [CNT_W-1:0]  mismatch_count
`endif
);
    localparam int IDX_W = $clog2(WORD_W);

    dtc_state_e       state;
    logic [IDX_W-1:0] bit_idx;
    logic             store;
    logic             restart;

    // In HUNT only a sync bit is stored; any valid sync restarts at bit 0.
    assign store   = sr_valid && (state == LOCKED || frame_sync);
    assign restart = sr_valid && frame_sync;

    dtc_deser_shift #(.WIDTH(WORD_W), .IDX_W(IDX_W)) u_shift (
        .clk     (clk),
        .rst     (rst),
        .din     (sr_in),
        .store   (store),
        .restart (restart),
        .bit_idx (bit_idx),
        .word    (wr_data),
        .done    (wr_en)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= HUNT;
            locked    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            case (state)
                HUNT: begin
                    if (sr_valid && frame_sync) begin
                        state  <= LOCKED;
                        locked <= 1'b1;
                    end
                end
                LOCKED: begin
                    if (sr_valid && frame_sync && bit_idx != '0)
                        frame_err <= 1'b1;
                end
                default: begin
                    state  <= HUNT;
                    locked <= 1'b0;
                end
            endcase
        end
    end

    // Address advances the cycle after the write so wr_addr names the word being written.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_addr    <= '0;
            word_count <= '0;
        end else if (wr_en) begin
            wr_addr    <= (wr_addr == ADDR_W'(DEPTH-1)) ? '0 : wr_addr + ADDR_W'(1);
            word_count <= sat_inc(word_count);
        end
    end

`ifdef DTC_DESER_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            mismatch       <= 1'b0;
            mismatch_count <= '0;
        end else begin
            mismatch <= wr_en && (wr_data != exp_data);
            if (wr_en && (wr_data != exp_data))
                mismatch_count <= sat_inc(mismatch_count);
        end
    end
`endif
endmodule

// File: tb/tb_dtc_deser.sv
// Randomized bench for dtc_deser against a frame-level queue model of the receive rules.
module tb_dtc_deser;
    import dtc_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              sr_in = 1'b0;
    logic              sr_valid = 1'b0;
    logic              frame_sync = 1'b0;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [WORD_W-1:0] wr_data;
    logic              locked;
    logic              frame_err;
    logic [CNT_W-1:0]  word_count;
`ifdef DTC_DESER_CHECK_EN
    logic [WORD_W-1:0] exp_data = '0;
    logic              mismatch;
    logic [CNT_W-1:0]  mismatch_count;
    bit                m_mis = 1'b0;
    int                m_mis_cnt = 0;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    dtc_deser dut (
        .clk            (clk),
        .rst            (rst),
        .sr_in          (sr_in),
        .sr_valid       (sr_valid),
        .frame_sync     (frame_sync),
        .wr_en          (wr_en),
        .wr_addr        (wr_addr),
        .wr_data        (wr_data),
        .locked         (locked),
        .frame_err      (frame_err),
        .word_count     (word_count)
`ifdef DTC_DESER_CHECK_EN
        ,
        .exp_data       (exp_data),
        .mismatch       (mismatch),
        .mismatch_count (mismatch_count)
`endif
    );

    // Model: hunting flag, bits of the frame in progress, writes seen so far,
    // and the outputs expected after the edge that consumes the current inputs.
    bit                m_hunt = 1'b1;
    bit                cur[$];
    int                m_writes = 0;
    bit                p_wr = 1'b0;
    bit                p_ferr = 1'b0;
    logic [WORD_W-1:0] p_data = '0;
    logic [WORD_W-1:0] w;

    task automatic chk(input string tag, input logic [WORD_W-1:0] got, input logic [WORD_W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input bit r, input bit v, input bit s, input bit b);
        @(negedge clk);
        chk("wr_en", wr_en, p_wr);
        chk("frame_err", frame_err, p_ferr);
        chk("locked", locked, !m_hunt);
        chk("wr_addr", wr_addr, m_writes % DEPTH);
        chk("word_count", word_count, (m_writes > 65535) ? 65535 : m_writes);
        if (p_wr) chk("wr_data", wr_data, p_data);
`ifdef DTC_DESER_CHECK_EN
        chk("mismatch", mismatch, m_mis);
        chk("mismatch_count", mismatch_count, m_mis_cnt);
        m_mis = 1'b0;
        exp_data = p_data;
        if (p_wr && m_writes == 3) exp_data[WORD_W-1] = ~p_data[WORD_W-1];
        if (p_wr && m_writes == 3 && !r) begin
            m_mis = 1'b1;
            m_mis_cnt++;
        end
        if (r) m_mis_cnt = 0;
`endif
        if (p_wr) m_writes++;
        rst = r; sr_valid = v; frame_sync = s; sr_in = b;
        p_wr = 1'b0;
        p_ferr = 1'b0;
        if (r) begin
            m_hunt = 1'b1;
            cur.delete();
            m_writes = 0;
        end else if (v) begin
            if (m_hunt) begin
                if (s) begin
                    m_hunt = 1'b0;
                    cur.push_back(b);
                end
            end else begin
                if (s && cur.size() != 0) begin
                    p_ferr = 1'b1;
                    cur.delete();
                end
                cur.push_back(b);
            end
            if (cur.size() == WORD_W) begin
                p_wr = 1'b1;
                for (int i = 0; i < WORD_W; i++) p_data[i] = cur[i];
                cur.delete();
            end
        end
    endtask

    // Sends the first n bits of word, sync on bit 0 if asked; gap puts an idle slot every 3rd cycle.
    task automatic send(input logic [WORD_W-1:0] wd, input int n, input bit sync0, input bit gap);
        int cyc = 0;
        for (int i = 0; i < n; i++) begin
            if (gap && (cyc % 3) == 2) begin
                step(1'b0, 1'b0, 1'($urandom), 1'($urandom));
                cyc++;
            end
            step(1'b0, 1'b1, sync0 && i == 0, wd[i]);
            cyc++;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'($urandom), 1'($urandom));
    endtask

    task automatic rand_word(output logic [WORD_W-1:0] r);
        for (int i = 0; i < WORD_W / 32; i++) r[i*32 +: 32] = $urandom;
    endtask

    initial begin
        repeat (3) step(1'b1, 1'b0, 1'b0, 1'b0);

        // Aligned stream
        w = 1;  send(w, WORD_W, 1'b1, 1'b0);
        w = '1; send(w, WORD_W, 1'b1, 1'b0);
        idle(3);
        chk("aligned_count", word_count, 2);
        chk("aligned_locked", locked, 1);

        // Pre-sync garbage
        repeat (2) step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 100; i++) step(1'b0, 1'b1, 1'b0, 1'($urandom));
        w = 256'hA5; send(w, WORD_W, 1'b1, 1'b0);
        idle(2);
        chk("presync_count", word_count, 1);

        // Misaligned sync at bit_idx 37, then a full frame
        rand_word(w); send(w, 37, 1'b1, 1'b0);
        rand_word(w); send(w, WORD_W, 1'b1, 1'b0);
        idle(2);
        chk("misalign_count", word_count, 2);

        // sr_valid gaps
        rand_word(w); send(w, WORD_W, 1'b1, 1'b1);
        idle(2);

        // Random frames, sync sometimes omitted, random gaps
        for (int f = 0; f < 6; f++) begin
            rand_word(w);
            send(w, WORD_W, 1'($urandom), 1'($urandom));
            if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 4));
        end

        // Wrap and reset mid-frame
        step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int f = 0; f < 25; f++) begin
            rand_word(w);
            send(w, WORD_W, 1'b1, 1'b0);
        end
        rand_word(w); send(w, 100, 1'b1, 1'b0);
        repeat (2) step(1'b1, 1'b1, 1'b0, 1'($urandom));
        idle(4);
        chk("reset_wr_data", wr_data, 0);
        chk("reset_locked", locked, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
